// File: rtl/uart_fx_master_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fx_master_if
// Purpose  : UART byte stream and fx_bus master signals of uart_fx_master.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fx_master_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_busy;
    logic        ufx_wr;
    logic [7:0]  ufx_data;
    logic [21:0] ufx_waddr;
    logic        ufx_rd;
    logic [21:0] ufx_raddr;
    logic [7:0]  ufx_q;

    modport master (
        input  rx_data, rx_vld, tx_busy, ufx_q,
        output tx_data, tx_vld, ufx_wr, ufx_data, ufx_waddr, ufx_rd, ufx_raddr
    );

    modport slave (
        output rx_data, rx_vld, tx_busy, ufx_q,
        input  tx_data, tx_vld, ufx_wr, ufx_data, ufx_waddr, ufx_rd, ufx_raddr
    );
endinterface
`default_nettype wire

// File: rtl/uart_fx_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_fx_master
// Purpose  : Parses UART byte frames into single fx_bus writes/reads and
//            returns one reply byte per frame. Optional macro FX_CHKSUM_EN
//            adds a trailing XOR checksum byte to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fx_master #(
    parameter int TIMEOUT = 50000,
    parameter int RD_LAT  = 2
) (
    input  wire logic        clk_sys,
    input  wire logic        rst_n,
    uart_fx_master_if.master bus
);
    localparam int                c_TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [2:0]        c_LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [7:0]        c_SYNC     = 8'h5A;
    localparam logic [7:0]        c_CMD_WR   = 8'h01;
    localparam logic [7:0]        c_CMD_RD   = 8'h02;
    localparam logic [7:0]        c_ACK      = 8'hAA;
    localparam logic [7:0]        c_NAK      = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CMD  = 4'd1,
        S_A2   = 4'd2,
        S_A1   = 4'd3,
        S_A0   = 4'd4,
        S_DAT  = 4'd5,
        S_CHK  = 4'd6,
        S_EXEC = 4'd7,
        S_RDW  = 4'd8,
        S_TX   = 4'd9
    } state_t;

`ifdef FX_CHKSUM_EN
    localparam state_t c_PAYLOAD_END = S_CHK;
    logic [7:0] r_chk, w_chk_nxt;
`else
    localparam state_t c_PAYLOAD_END = S_EXEC;
`endif

    state_t            r_state, w_nxt;
    logic              r_is_rd, w_is_rd_nxt;
    logic [21:0]       r_addr, w_addr_nxt;
    logic [7:0]        r_dat, w_dat_nxt;
    logic [7:0]        r_reply, w_reply_nxt;
    logic [2:0]        r_lat, w_lat_nxt;
    logic [c_TO_W-1:0] r_tocnt;
    logic              w_to_inc;
    logic              w_enter_exec;
    logic              w_tx_vld;
    logic              r_wr, r_rd;
    logic [21:0]       r_waddr, r_raddr;
    logic [7:0]        r_wdata;

    always_comb begin
        w_nxt        = r_state;
        w_is_rd_nxt  = r_is_rd;
        w_addr_nxt   = r_addr;
        w_dat_nxt    = r_dat;
        w_reply_nxt  = r_reply;
        w_lat_nxt    = r_lat;
        w_to_inc     = 1'b0;
        w_tx_vld     = 1'b0;
`ifdef FX_CHKSUM_EN
        w_chk_nxt    = r_chk;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.rx_vld && bus.rx_data == c_SYNC) begin
                    w_nxt = S_CMD;
`ifdef FX_CHKSUM_EN
                    w_chk_nxt = 8'h00;
`endif
                end
            end
            S_CMD, S_A2, S_A1, S_A0, S_DAT, S_CHK: begin
                // A byte in the expiry cycle takes precedence over the timeout.
                if (bus.rx_vld) begin
`ifdef FX_CHKSUM_EN
                    w_chk_nxt = r_chk ^ bus.rx_data;
`endif
                    unique case (r_state)
                        S_CMD: begin
                            if (bus.rx_data == c_CMD_WR || bus.rx_data == c_CMD_RD) begin
                                w_is_rd_nxt = bus.rx_data[1];
                                w_nxt       = S_A2;
                            end else begin
                                w_reply_nxt = c_NAK;
                                w_nxt       = S_TX;
                            end
                        end
                        S_A2: begin
                            w_addr_nxt[21:16] = bus.rx_data[5:0];
                            w_nxt             = S_A1;
                        end
                        S_A1: begin
                            w_addr_nxt[15:8] = bus.rx_data;
                            w_nxt            = S_A0;
                        end
                        S_A0: begin
                            w_addr_nxt[7:0] = bus.rx_data;
                            w_nxt           = r_is_rd ? c_PAYLOAD_END : S_DAT;
                        end
                        S_DAT: begin
                            w_dat_nxt = bus.rx_data;
                            w_nxt     = c_PAYLOAD_END;
                        end
                        default: begin
`ifdef FX_CHKSUM_EN
                            if (bus.rx_data == r_chk) begin
                                w_nxt = S_EXEC;
                            end else begin
                                w_reply_nxt = c_NAK;
                                w_nxt       = S_TX;
                            end
`else
                            w_nxt = S_IDLE;
`endif
                        end
                    endcase
                end else if (r_tocnt == c_TO_LAST) begin
                    w_nxt = S_IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_EXEC: begin
                if (r_is_rd) begin
                    w_lat_nxt = 3'd0;
                    w_nxt     = S_RDW;
                end else begin
                    w_reply_nxt = c_ACK;
                    w_nxt       = S_TX;
                end
            end
            S_RDW: begin
                if (r_lat == c_LAT_LAST) begin
                    w_reply_nxt = bus.ufx_q;
                    w_nxt       = S_TX;
                end else begin
                    w_lat_nxt = r_lat + 3'd1;
                end
            end
            S_TX: begin
                if (!bus.tx_busy) begin
                    w_tx_vld = 1'b1;
                    w_nxt    = S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        w_enter_exec = (w_nxt == S_EXEC) && (r_state != S_EXEC);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
            r_reply <= '0;
            r_lat   <= '0;
            r_tocnt <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
`ifdef FX_CHKSUM_EN
            r_chk   <= '0;
`endif
        end else begin
            r_is_rd <= w_is_rd_nxt;
            r_addr  <= w_addr_nxt;
            r_dat   <= w_dat_nxt;
            r_reply <= w_reply_nxt;
            r_lat   <= w_lat_nxt;
            r_tocnt <= w_to_inc ? r_tocnt + 1'b1 : '0;
`ifdef FX_CHKSUM_EN
            r_chk   <= w_chk_nxt;
`endif
            // Bus outputs load on the edge entering EXEC so the strobe and its
            // address/data appear together and then hold until the next strobe.
            r_wr <= w_enter_exec && !r_is_rd;
            r_rd <= w_enter_exec && r_is_rd;
            if (w_enter_exec) begin
                if (r_is_rd) begin
                    r_raddr <= w_addr_nxt;
                end else begin
                    r_waddr <= w_addr_nxt;
                    r_wdata <= w_dat_nxt;
                end
            end
        end
    end

    assign bus.tx_data   = r_reply;
    assign bus.tx_vld    = w_tx_vld;
    assign bus.ufx_wr    = r_wr;
    assign bus.ufx_data  = r_wdata;
    assign bus.ufx_waddr = r_waddr;
    assign bus.ufx_rd    = r_rd;
    assign bus.ufx_raddr = r_raddr;
endmodule
`default_nettype wire

// File: tb/tb_uart_fx_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fx_master
// Purpose  : Self-checking bench for uart_fx_master (frames, timeout, busy,
//            reset during read; checksum cases when FX_CHKSUM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fx_master;
    localparam int TB_TIMEOUT = 40;
    localparam int TB_RD_LAT  = 3;

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        int              hdr;
        bit              add_chk;
        int              gap_at;
        int              gap;
        logic [7:0]      q;
        int              e_wr;
        int              e_rd;
        int              e_tx;
        logic [7:0]      e_txd;
        logic [21:0]     e_waddr;
        logic [7:0]      e_wdata;
        logic [21:0]     e_raddr;
        int              e_wlat;
        int              e_rlat;
        int              e_txlat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_fx_master_if bus_if ();

    uart_fx_master #(.TIMEOUT(TB_TIMEOUT), .RD_LAT(TB_RD_LAT)) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus_if.master)
    );

    // Slave model: drives read data only in the cycle RD_LAT after ufx_rd.
    logic [7:0] slave_val;
    logic [7:0] rd_pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe <= '0;
        else        rd_pipe <= {rd_pipe[6:0], bus_if.ufx_rd};
    end
    assign bus_if.ufx_q = rd_pipe[TB_RD_LAT-1] ? slave_val : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, overlap = 0, busy_viol = 0;
    int last_rx_cyc = 0, wr_cyc = 0, rd_cyc = 0, tx_cyc = 0;
    logic [7:0] tx_byte = 8'h00;
    always @(negedge clk) begin
        if (bus_if.rx_vld) last_rx_cyc = cyc;
        if (bus_if.ufx_wr) begin wr_cnt++; wr_cyc = cyc; end
        if (bus_if.ufx_rd) begin rd_cnt++; rd_cyc = cyc; end
        if (bus_if.tx_vld) begin tx_cnt++; tx_cyc = cyc; tx_byte = bus_if.tx_data; end
        if (bus_if.ufx_wr && bus_if.ufx_rd) overlap++;
        if (bus_if.tx_vld && bus_if.tx_busy) busy_viol++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data = b;
        bus_if.rx_vld  = 1'b1;
        @(posedge clk); #1;
        bus_if.rx_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

`ifdef FX_CHKSUM_EN
    function automatic logic [7:0] frame_chk(input vec_t v);
        logic [7:0] x = 8'h00;
        for (int i = v.hdr + 1; i < v.n; i++) x ^= v.b[i];
        return x;
    endfunction
`endif

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[i]);
            if (i == v.gap_at) idle(v.gap);
        end
`ifdef FX_CHKSUM_EN
        if (v.add_chk) send_byte(frame_chk(v));
`endif
    endtask

    function automatic vec_t mk(input logic [0:7][7:0] b, input int n, input int hdr,
                                input bit add_chk, input int gap_at, input int gap,
                                input logic [7:0] q, input int e_wr, input int e_rd,
                                input int e_tx, input logic [7:0] e_txd,
                                input logic [21:0] e_waddr, input logic [7:0] e_wdata,
                                input logic [21:0] e_raddr, input int e_wlat,
                                input int e_rlat, input int e_txlat);
        vec_t v;
        v.b = b; v.n = n; v.hdr = hdr; v.add_chk = add_chk; v.gap_at = gap_at; v.gap = gap;
        v.q = q; v.e_wr = e_wr; v.e_rd = e_rd; v.e_tx = e_tx; v.e_txd = e_txd;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_raddr = e_raddr;
        v.e_wlat = e_wlat; v.e_rlat = e_rlat; v.e_txlat = e_txlat;
        return v;
    endfunction

    vec_t vecs [8];
    int   b_wr, b_rd, b_tx, fall_cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus_if.rx_data = 8'h00;
        bus_if.rx_vld  = 1'b0;
        bus_if.tx_busy = 1'b0;
        slave_val      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data",   32'(bus_if.tx_data),   32'h0);
        chk("rst_tx_vld",    32'(bus_if.tx_vld),    32'h0);
        chk("rst_ufx_wr",    32'(bus_if.ufx_wr),    32'h0);
        chk("rst_ufx_data",  32'(bus_if.ufx_data),  32'h0);
        chk("rst_ufx_waddr", 32'(bus_if.ufx_waddr), 32'h0);
        chk("rst_ufx_rd",    32'(bus_if.ufx_rd),    32'h0);
        chk("rst_ufx_raddr", 32'(bus_if.ufx_raddr), 32'h0);
        rst_n = 1'b1;
        idle(2);

        //              bytes                                                    n  hdr chk gap_at gap         q      wr rd tx txd    waddr       wdata  raddr       wl rl txl
        vecs[0] = mk({8'h5A,8'h01,8'h00,8'h12,8'h34,8'h77,8'h00,8'h00}, 6, 0, 1, -1, 0,            8'h00, 1, 0, 1, 8'hAA, 22'h001234, 8'h77, 22'h000000, 1, 0, 2);
        vecs[1] = mk({8'h5A,8'h02,8'h3F,8'hFF,8'hFF,8'h00,8'h00,8'h00}, 5, 0, 1, -1, 0,            8'h9C, 0, 1, 1, 8'h9C, 22'h001234, 8'h77, 22'h3FFFFF, 0, 1, 5);
        vecs[2] = mk({8'h00,8'hFF,8'h5A,8'h03,8'h00,8'h00,8'h00,8'h00}, 4, 2, 0, -1, 0,            8'h00, 0, 0, 1, 8'hEE, 22'h001234, 8'h77, 22'h3FFFFF, 0, 0, 0);
        vecs[3] = mk({8'h5A,8'h01,8'hC1,8'h02,8'h03,8'hA5,8'h00,8'h00}, 6, 0, 1, -1, 0,            8'h00, 1, 0, 1, 8'hAA, 22'h010203, 8'hA5, 22'h3FFFFF, 1, 0, 2);
        vecs[4] = mk({8'h5A,8'h01,8'h00,8'h5A,8'h02,8'h00,8'h00,8'h05}, 8, 3, 1, 2, TB_TIMEOUT+2,  8'h3C, 0, 1, 1, 8'h3C, 22'h010203, 8'hA5, 22'h000005, 0, 1, 5);
        vecs[5] = mk({8'h5A,8'h02,8'h00,8'h00,8'h07,8'h00,8'h00,8'h00}, 5, 0, 1, 1, TB_TIMEOUT-1,  8'h11, 0, 1, 1, 8'h11, 22'h010203, 8'hA5, 22'h000007, 0, 1, 5);
        vecs[6] = mk({8'h5A,8'h02,8'h00,8'h00,8'h08,8'h00,8'h00,8'h00}, 5, 0, 1, 1, TB_TIMEOUT,    8'h22, 0, 0, 0, 8'h00, 22'h010203, 8'hA5, 22'h000007, 0, 0, 0);
        vecs[7] = mk({8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 0, -1, 0,            8'h00, 0, 0, 1, 8'hEE, 22'h010203, 8'hA5, 22'h000007, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            b_wr = wr_cnt; b_rd = rd_cnt; b_tx = tx_cnt;
            slave_val = vecs[i].q;
            send_vec(vecs[i]);
            idle(12);
            chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - b_wr), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - b_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_tx_cnt", i), 32'(tx_cnt - b_tx), 32'(vecs[i].e_tx));
            chk($sformatf("v%0d_waddr", i),  32'(bus_if.ufx_waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("v%0d_wdata", i),  32'(bus_if.ufx_data),  32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_raddr", i),  32'(bus_if.ufx_raddr), 32'(vecs[i].e_raddr));
            if (vecs[i].e_tx > 0)    chk($sformatf("v%0d_tx_byte", i), 32'(tx_byte), 32'(vecs[i].e_txd));
            if (vecs[i].e_wlat > 0)  chk($sformatf("v%0d_wr_lat", i), 32'(wr_cyc - last_rx_cyc), 32'(vecs[i].e_wlat));
            if (vecs[i].e_rlat > 0)  chk($sformatf("v%0d_rd_lat", i), 32'(rd_cyc - last_rx_cyc), 32'(vecs[i].e_rlat));
            if (vecs[i].e_txlat > 0) chk($sformatf("v%0d_tx_lat", i), 32'(tx_cyc - last_rx_cyc), 32'(vecs[i].e_txlat));
        end

        // Reply held back by tx_busy for 100 cycles.
        b_wr = wr_cnt; b_tx = tx_cnt;
        bus_if.tx_busy = 1'b1;
        send_vec(mk({8'h5A,8'h01,8'h2A,8'hBC,8'hDE,8'h01,8'h00,8'h00}, 6, 0, 1, -1, 0,
                    8'h00, 1, 0, 1, 8'hAA, 22'h2ABCDE, 8'h01, 22'h000007, 1, 0, 2));
        idle(100);
        chk("busy_tx_held", 32'(tx_cnt - b_tx), 32'd0);
        bus_if.tx_busy = 1'b0;
        fall_cyc = cyc;
        idle(5);
        chk("busy_tx_cnt",  32'(tx_cnt - b_tx), 32'd1);
        chk("busy_tx_cyc",  32'(tx_cyc - fall_cyc), 32'd0);
        chk("busy_tx_byte", 32'(tx_byte), 32'hAA);
        chk("busy_wr_cnt",  32'(wr_cnt - b_wr), 32'd1);
        chk("busy_waddr",   32'(bus_if.ufx_waddr), 32'h2ABCDE);

`ifdef FX_CHKSUM_EN
        // Write frame with corrupted checksum (correct value is 0x50).
        b_wr = wr_cnt; b_tx = tx_cnt;
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h77); send_byte(8'h51);
        idle(10);
        chk("badchk_wr_cnt",  32'(wr_cnt - b_wr), 32'd0);
        chk("badchk_tx_cnt",  32'(tx_cnt - b_tx), 32'd1);
        chk("badchk_tx_byte", 32'(tx_byte), 32'hEE);
`endif

        // Reset asserted while the read is waiting for slave data.
        b_rd = rd_cnt; b_tx = tx_cnt;
        slave_val = 8'h5E;
        send_vec(mk({8'h5A,8'h02,8'h01,8'h02,8'h03,8'h00,8'h00,8'h00}, 5, 0, 1, -1, 0,
                    8'h5E, 0, 1, 1, 8'h5E, 22'h0, 8'h0, 22'h010203, 0, 1, 5));
        for (int k = 0; k < 20 && rd_cnt == b_rd; k++) idle(1);
        chk("rdw_rd_seen", 32'(rd_cnt - b_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rdw_rst_tx_data",   32'(bus_if.tx_data),   32'h0);
        chk("rdw_rst_tx_vld",    32'(bus_if.tx_vld),    32'h0);
        chk("rdw_rst_ufx_wr",    32'(bus_if.ufx_wr),    32'h0);
        chk("rdw_rst_ufx_data",  32'(bus_if.ufx_data),  32'h0);
        chk("rdw_rst_ufx_waddr", 32'(bus_if.ufx_waddr), 32'h0);
        chk("rdw_rst_ufx_rd",    32'(bus_if.ufx_rd),    32'h0);
        chk("rdw_rst_ufx_raddr", 32'(bus_if.ufx_raddr), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(12);
        chk("rdw_no_tx", 32'(tx_cnt - b_tx), 32'd0);
        chk("rdw_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);

        chk("wr_rd_overlap", 32'(overlap), 32'd0);
        chk("tx_vld_while_busy", 32'(busy_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
